systolic_array_2x2: RTL and testbench
=====================================

# systolic_array_2x2

Output-stationary 2×2 systolic matrix multiplier that computes C = A·B from skewed activation and weight streams. It sits directly downstream of the activation skew stage, consuming its `a_in1`/`a_in2` beats, plus a matching skewed weight stream on `b_in1`/`b_in2`. It holds the four unsigned dot-product results until the next start and flags completion with a one-cycle `done` pulse.

## Interface
- `DATA_W`, 8: width of each activation/weight element, unsigned.
- `ACC_W`, 17: accumulator/result width; must be ≥ 2·DATA_W+1.

- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: one clock; reset is synchronous and active-low.
- `start` in 1: pulse marking beat 0 of a skewed stream.
- `a_in1` in DATA_W: row-0 activation beat; beats 0,1,2 carry a11, a12, 0.
- `a_in2` in DATA_W: row-1 activation beat; beats 0,1,2 carry 0, a21, a22.
- `b_in1` in DATA_W: column-0 weight beat; beats 0,1,2 carry b11, b21, 0.
- `b_in2` in DATA_W: column-1 weight beat; beats 0,1,2 carry 0, b12, b22.
- `c11`,`c12`,`c21`,`c22` out ACC_W: result registers.
- `busy` out 1: high while in COMPUTE.
- `done` out 1: one-cycle completion pulse.

## Operation
- PE(i,j), i,j ∈ {0,1}: a operand from `a_in(i+1)` (j=0) or PE(i,0)'s forwarded-a register (j=1). b operand from `b_in(j+1)` (i=0) or PE(0,j)'s forwarded-b register (i=1).
- Every edge, each PE registers its a/b operands into its forward registers, regardless of state.
- Beat counter k: beat 0 is the edge where `start` is sampled in IDLE; beats 1–3 follow.
- Accumulation gating per PE:
  - beat k = i+j: acc ← a·b (overwrite; no explicit clear).
  - beat k = i+j+1: acc ← acc + a·b.
  - all other edges: hold.
- After beat 3: c11 = a11·b11+a12·b21, c12 = a11·b12+a12·b22, c21 = a21·b11+a22·b21, c22 = a21·b12+a22·b22.
- Arithmetic: unsigned DATA_W×DATA_W → 2·DATA_W product, zero-extended to ACC_W. No overflow is possible at the defaults.
- Results hold until the next accepted start. Each PE's output changes only on its own beats.
- State machine:
  - IDLE: on `start`, perform beat 0 and go to COMPUTE with k=1.
  - COMPUTE: beats 1..3, k increments each edge; the beat-3 edge goes to DONE.
  - DONE: one cycle, then IDLE.
- `start` is ignored in COMPUTE and DONE.

## Timing
- Reset (`reset`=0 at an edge): state IDLE, k=0, all accumulators and forward registers 0; outputs `c*`=0, `busy`=0, `done`=0.
- A reset mid-COMPUTE aborts the operation. It completes no result and produces no `done` pulse.
- `busy` is high for the 3 cycles following the start edge (beats 1–3).
- `done` is high in the cycle after the beat-3 edge. Latency: start edge → `done` high = 4 cycles.
- All `c*` are final when `done` is high.
- Minimum start-to-start spacing is 5 cycles. A `start` in the cycle `done` is high is dropped.
- Inputs sampled on beats 1–3 outside the gating windows have no effect. Nonzero garbage on `a_in*`/`b_in*` at beat 3 therefore cannot corrupt results.

## Structure
- Shared package `tpu_pkg`: DATA_W/ACC_W defaults and the `mmu_state_t` enum {IDLE, COMPUTE, DONE}.
- Sub-module `pe`:
  - ports: clk, reset, a_in, b_in, load, acc_en, a_out, b_out, acc.
  - instantiated 4× in the top.
- Top-level logic: FSM, beat counter, and per-PE load/acc_en decode from k.

## Test plan
- Basic product: A=[[1,2],[3,4]], B=[[5,6],[7,8]] skewed per Operation → `done` 4 cycles after start; c11=19, c12=22, c21=43, c22=50.
- Max values: all elements 255 → every c = 130050, no wrap in 17 bits.
- Back-to-back: second product A=I, B=[[9,8],[7,6]] started exactly 5 cycles after the first → c=9,8,7,6. No residue from the prior run. A `start` placed during `busy` is ignored.
- Garbage tolerance: drive 0xFF on all inputs at beat 3 and on the zero-padding slots of beats 0–2 → results unchanged from the clean case.
- Reset mid-op: assert `reset`=0 at beat 2 → next cycle all `c*`=0, `busy`=0, and `done` never pulses. A fresh start then computes correctly.
- Hold: with no start for 20 cycles after `done`, `c*` remain stable and `done` stays low.

Source files
------------

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared widths and matrix-unit state encoding.
package tpu_pkg;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 17;
    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} mmu_state_t;
endpackage

// File: rtl/pe.sv
// pe: systolic processing element with operand forwarding and a gated multiply-accumulate.
// Ports: clk, reset (sync, active-low); a_in/b_in operands; load overwrites acc with a*b,
// acc_en adds a*b to acc; a_out/b_out forward the registered operands; acc is the result.
module pe
    import tpu_pkg::*;
#(
    parameter int DATA_W = tpu_pkg::DATA_W,
    parameter int ACC_W  = tpu_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              load,
    input  logic              acc_en,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ACC_W-1:0]  acc
);
    logic [DATA_W-1:0]   a_q, b_q;
    logic [ACC_W-1:0]    acc_q, acc_d, prod;
    logic [2*DATA_W-1:0] mul;
    assign mul   = a_in * b_in;
    assign prod  = ACC_W'(mul);
    assign acc_d = load ? prod : acc_en ? acc_q + prod : acc_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_in;
            b_q   <= b_in;
            acc_q <= acc_d;
        end
    end
    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;
endmodule

// File: rtl/systolic_array_2x2.sv
// systolic_array_2x2: output-stationary 2x2 matrix multiplier fed by skewed a/b streams.
// Ports: clk, reset (sync, active-low), start (beat-0 pulse), a_in1/a_in2 skewed activation rows,
// b_in1/b_in2 skewed weight columns, c11..c22 held results, busy (COMPUTE), done (one-cycle pulse).
module systolic_array_2x2
    import tpu_pkg::*;
#(
    parameter int DATA_W = tpu_pkg::DATA_W,
    parameter int ACC_W  = tpu_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a_in1,
    input  logic [DATA_W-1:0] a_in2,
    input  logic [DATA_W-1:0] b_in1,
    input  logic [DATA_W-1:0] b_in2,
    output logic [ACC_W-1:0]  c11,
    output logic [ACC_W-1:0]  c12,
    output logic [ACC_W-1:0]  c21,
    output logic [ACC_W-1:0]  c22,
    output logic              busy,
    output logic              done
);
    mmu_state_t state_q, state_d;
    logic [1:0] k_q, k_d, beat;
    logic       active;
    logic [DATA_W-1:0] a_fwd [2][2];
    logic [DATA_W-1:0] b_fwd [2][2];
    logic [ACC_W-1:0]  acc   [2][2];
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = COMPUTE;
                k_d     = 2'd1;
            end
            COMPUTE: begin
                k_d     = k_q + 2'd1;
                state_d = (k_q == 2'd3) ? DONE : COMPUTE;
            end
            default: state_d = IDLE;
        endcase
    end
    // Beat 0 happens on the accepting IDLE edge itself, so it is decoded from start, not k.
    assign active = (state_q == IDLE && start) || state_q == COMPUTE;
    assign beat   = (state_q == COMPUTE) ? k_q : 2'd0;
    for (genvar i = 0; i < 2; i++) begin : g_row
        for (genvar j = 0; j < 2; j++) begin : g_col
            logic [DATA_W-1:0] a_op, b_op;
            assign a_op = (j == 0) ? ((i == 0) ? a_in1 : a_in2) : a_fwd[i][0];
            assign b_op = (i == 0) ? ((j == 0) ? b_in1 : b_in2) : b_fwd[0][j];
            pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
                .clk    (clk),
                .reset  (reset),
                .a_in   (a_op),
                .b_in   (b_op),
                .load   (active && beat == 2'(i + j)),
                .acc_en (active && beat == 2'(i + j + 1)),
                .a_out  (a_fwd[i][j]),
                .b_out  (b_fwd[i][j]),
                .acc    (acc[i][j])
            );
        end
    end
    // Edge PEs forward operands that leave the array.
    logic unused_fwd;
    assign unused_fwd = ^{a_fwd[0][1], a_fwd[1][1], b_fwd[1][0], b_fwd[1][1]};
    assign c11  = acc[0][0];
    assign c12  = acc[0][1];
    assign c21  = acc[1][0];
    assign c22  = acc[1][1];
    assign busy = (state_q == COMPUTE);
    assign done = (state_q == DONE);
endmodule

// File: tb/tb_systolic_array_2x2.sv
// tb_systolic_array_2x2: scoreboard bench for the 2x2 systolic multiplier.
module tb_systolic_array_2x2;
    logic        clk = 0, reset = 0, start = 0;
    logic [7:0]  a_in1 = 0, a_in2 = 0, b_in1 = 0, b_in2 = 0;
    logic [16:0] c11, c12, c21, c22;
    logic        busy, done;
    int          total = 0, bad = 0;
    logic [67:0] sb [$];
    logic [67:0] exp_c;
    logic [2:0]  busy_seen, done_seen;

    systolic_array_2x2 dut (
        .clk(clk), .reset(reset), .start(start),
        .a_in1(a_in1), .a_in2(a_in2), .b_in1(b_in1), .b_in2(b_in2),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // am = {a11,a12,a21,a22}, bm = {b11,b12,b21,b22}; result = {c11,c12,c21,c22}
    function automatic logic [67:0] mm(input logic [31:0] am, input logic [31:0] bm);
        logic [16:0] a11, a12, a21, a22, b11, b12, b21, b22;
        a11 = 17'(am[31:24]); a12 = 17'(am[23:16]); a21 = 17'(am[15:8]); a22 = 17'(am[7:0]);
        b11 = 17'(bm[31:24]); b12 = 17'(bm[23:16]); b21 = 17'(bm[15:8]); b22 = 17'(bm[7:0]);
        return {a11*b11 + a12*b21, a11*b12 + a12*b22, a21*b11 + a22*b21, a21*b12 + a22*b22};
    endfunction

    // Drives one skewed operation starting at the next falling edge; returns in the cycle done should be high.
    task automatic drive_op(input logic [31:0] am, input logic [31:0] bm, input logic g, input logic stray);
        logic [7:0] p;
        p = g ? 8'hFF : 8'h00;
        sb.push_back(mm(am, bm));
        @(negedge clk);
        start = 1; a_in1 = am[31:24]; a_in2 = p; b_in1 = bm[31:24]; b_in2 = p;
        @(negedge clk);
        busy_seen[0] = busy; done_seen[0] = done;
        start = 0; a_in1 = am[23:16]; a_in2 = am[15:8]; b_in1 = bm[15:8]; b_in2 = bm[23:16];
        @(negedge clk);
        busy_seen[1] = busy; done_seen[1] = done;
        start = stray; a_in1 = p; a_in2 = am[7:0]; b_in1 = p; b_in2 = bm[7:0];
        @(negedge clk);
        busy_seen[2] = busy; done_seen[2] = done;
        start = 0; a_in1 = p; a_in2 = p; b_in1 = p; b_in2 = p;
        @(negedge clk);
        a_in1 = 0; a_in2 = 0; b_in1 = 0; b_in2 = 0;
    endtask

    task automatic test_reset;
        reset = 0;
        repeat (2) @(negedge clk);
        total++; if ({c11, c12, c21, c22} !== 68'd0) begin bad++; $display("FAIL reset_c got=%0d,%0d,%0d,%0d want 0", c11, c12, c21, c22); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want 0", done); end
        reset = 1;
    endtask

    task automatic test_basic;
        drive_op({8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8}, 0, 0);
        total++; if (busy_seen !== 3'b111) begin bad++; $display("FAIL basic_busy got=%b want 111", busy_seen); end
        total++; if (done_seen !== 3'b000) begin bad++; $display("FAIL basic_early_done got=%b want 000", done_seen); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done_latency got=%b want 1", done); end
        exp_c = sb.pop_front();
        total++; if (exp_c !== {17'd19, 17'd22, 17'd43, 17'd50}) begin bad++; $display("FAIL basic_model got=%h", exp_c); end
        total++; if ({c11, c12, c21, c22} !== exp_c) begin bad++; $display("FAIL basic_c got=%0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d", c11, c12, c21, c22, exp_c[67:51], exp_c[50:34], exp_c[33:17], exp_c[16:0]); end
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_pulse done=%b busy=%b want 0,0", done, busy); end
    endtask

    task automatic test_max;
        drive_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL max_done got=%b want 1", done); end
        exp_c = sb.pop_front();
        total++; if ({c11, c12, c21, c22} !== {4{17'd130050}}) begin bad++; $display("FAIL max_c got=%0d,%0d,%0d,%0d want 130050", c11, c12, c21, c22); end
        total++; if ({c11, c12, c21, c22} !== exp_c) begin bad++; $display("FAIL max_model got=%0d,%0d,%0d,%0d", c11, c12, c21, c22); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        drive_op({8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8}, 0, 1);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_first_done got=%b want 1", done); end
        exp_c = sb.pop_front();
        total++; if ({c11, c12, c21, c22} !== exp_c) begin bad++; $display("FAIL b2b_first_c got=%0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d", c11, c12, c21, c22, exp_c[67:51], exp_c[50:34], exp_c[33:17], exp_c[16:0]); end
        start = 1; a_in1 = 8'hFF; b_in1 = 8'hFF;
        drive_op({8'd1, 8'd0, 8'd0, 8'd1}, {8'd9, 8'd8, 8'd7, 8'd6}, 0, 1);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_second_done got=%b want 1", done); end
        exp_c = sb.pop_front();
        total++; if ({c11, c12, c21, c22} !== {17'd9, 17'd8, 17'd7, 17'd6}) begin bad++; $display("FAIL b2b_second_c got=%0d,%0d,%0d,%0d want 9,8,7,6", c11, c12, c21, c22); end
        total++; if ({c11, c12, c21, c22} !== exp_c) begin bad++; $display("FAIL b2b_second_model got=%0d,%0d,%0d,%0d", c11, c12, c21, c22); end
        @(negedge clk);
    endtask

    task automatic test_garbage;
        drive_op({8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8}, 1, 0);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL garbage_done got=%b want 1", done); end
        exp_c = sb.pop_front();
        total++; if ({c11, c12, c21, c22} !== exp_c) begin bad++; $display("FAIL garbage_c got=%0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d", c11, c12, c21, c22, exp_c[67:51], exp_c[50:34], exp_c[33:17], exp_c[16:0]); end
        @(negedge clk);
    endtask

    task automatic test_reset_midop;
        @(negedge clk);
        start = 1; a_in1 = 8'd1; b_in1 = 8'd5;
        @(negedge clk);
        start = 0; a_in1 = 8'd2; a_in2 = 8'd3; b_in1 = 8'd7; b_in2 = 8'd6;
        @(negedge clk);
        reset = 0; a_in1 = 8'd0; a_in2 = 8'd4; b_in1 = 8'd0; b_in2 = 8'd8;
        @(negedge clk);
        total++; if ({c11, c12, c21, c22} !== 68'd0) begin bad++; $display("FAIL midop_c got=%0d,%0d,%0d,%0d want 0", c11, c12, c21, c22); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midop_flags busy=%b done=%b want 0,0", busy, done); end
        reset = 1; a_in2 = 0; b_in2 = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            total++; if (done !== 1'b0) begin bad++; $display("FAIL midop_no_done cycle=%0d got=%b want 0", n, done); end
        end
        drive_op({8'd2, 8'd3, 8'd4, 8'd5}, {8'd6, 8'd7, 8'd8, 8'd9}, 0, 0);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL midop_fresh_done got=%b want 1", done); end
        exp_c = sb.pop_front();
        total++; if ({c11, c12, c21, c22} !== exp_c) begin bad++; $display("FAIL midop_fresh_c got=%0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d", c11, c12, c21, c22, exp_c[67:51], exp_c[50:34], exp_c[33:17], exp_c[16:0]); end
    endtask

    task automatic test_hold;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            total++; if ({c11, c12, c21, c22} !== exp_c || done !== 1'b0) begin bad++; $display("FAIL hold cycle=%0d got=%0d,%0d,%0d,%0d done=%b want %0d,%0d,%0d,%0d done=0", n, c11, c12, c21, c22, done, exp_c[67:51], exp_c[50:34], exp_c[33:17], exp_c[16:0]); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_basic;
        test_max;
        test_back_to_back;
        test_garbage;
        test_reset_midop;
        test_hold;
        total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
